// File: rtl/cntclk_seq.sv
// rtl/cntclk_seq.sv - programmable clock-pattern sequencer driven by a (half-period, repeat) table
module cntclk_seq #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int RPT_W = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_period,
   input  logic [RPT_W-1:0] i_wr_repeat,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_loop,
   output logic             o_clk,
   output logic             o_edge,
   output logic             o_busy,
   output logic             o_done,
   output logic [AW-1:0]    o_idx
);

   localparam logic [0:0]    ST_IDLE  = 1'b0;
   localparam logic [0:0]    ST_RUN   = 1'b1;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   logic [WIDTH-1:0] per_mem [DEPTH];
   logic [RPT_W-1:0] rpt_mem [DEPTH];

   logic [0:0]       state;
   logic [WIDTH-1:0] cnt;
   logic [RPT_W:0]   hc;
   logic [AW-1:0]    idx;

   logic [AW-1:0]    nxt_idx;
   logic [RPT_W+1:0] hc_inc;
   logic [RPT_W+1:0] toggles_req;
   logic             last_toggle;
   logic             end_of_list;
   logic             can_loop;

   // Countdown reload is Pe-1, with a programmed period of 0 behaving as 1
   function automatic logic [WIDTH-1:0] reload_of(input logic [WIDTH-1:0] p);
      return (p == '0) ? '0 : p - WIDTH'(1);
   endfunction

   assign o_idx = idx;

   // Table write port; entries may change at any time, readers see the pre-edge value
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            per_mem[i] <= '0;
            rpt_mem[i] <= '0;
         end
      end else if (i_wr_en && (int'(i_wr_addr) < DEPTH)) begin
         per_mem[i_wr_addr] <= i_wr_period;
         rpt_mem[i_wr_addr] <= i_wr_repeat;
      end
   end

   // Decide, at a toggle, whether the entry continues, advances, loops or finishes
   always_comb begin
      nxt_idx     = (idx == LAST_IDX) ? '0 : idx + AW'(1);
      hc_inc      = {1'b0, hc} + (RPT_W+2)'(1);
      toggles_req = (RPT_W+2)'({rpt_mem[idx], 1'b0});
      last_toggle = !(hc_inc < toggles_req);
      end_of_list = (idx == LAST_IDX) || (rpt_mem[nxt_idx] == '0);
      can_loop    = i_loop && (rpt_mem[0] != '0);
   end

   // Run control: start/stop handling, half-period countdown and entry sequencing
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         hc     <= '0;
         idx    <= '0;
         o_clk  <= 1'b0;
         o_edge <= 1'b0;
         o_busy <= 1'b0;
         o_done <= 1'b0;
      end else begin
         o_edge <= 1'b0;
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start && !i_stop) begin
                  if (rpt_mem[0] == '0) begin
                     // empty list: report completion without ever running
                     o_done <= 1'b1;
                  end else begin
                     state  <= ST_RUN;
                     idx    <= '0;
                     cnt    <= reload_of(per_mem[0]);
                     hc     <= '0;
                     o_clk  <= 1'b0;
                     o_busy <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (i_stop) begin
                  // abort wins over any toggle or advance due this cycle
                  state  <= ST_IDLE;
                  o_clk  <= 1'b0;
                  o_busy <= 1'b0;
                  idx    <= '0;
                  cnt    <= '0;
                  hc     <= '0;
               end else if (cnt != '0) begin
                  cnt <= cnt - WIDTH'(1);
               end else begin
                  o_clk  <= ~o_clk;
                  o_edge <= 1'b1;
                  if (!last_toggle) begin
                     hc  <= hc_inc[RPT_W:0];
                     cnt <= reload_of(per_mem[idx]);
                  end else if (!end_of_list) begin
                     idx <= nxt_idx;
                     cnt <= reload_of(per_mem[nxt_idx]);
                     hc  <= '0;
                  end else if (can_loop) begin
                     idx <= '0;
                     cnt <= reload_of(per_mem[0]);
                     hc  <= '0;
                  end else begin
                     state  <= ST_IDLE;
                     o_busy <= 1'b0;
                     o_done <= 1'b1;
                     idx    <= '0;
                     cnt    <= '0;
                     hc     <= '0;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cntclk_seq.sv
// tb/tb_cntclk_seq.sv - self-checking bench for cntclk_seq against a schedule-based reference model
module tb_cntclk_seq;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int RPT_W = 8;
   localparam int AW    = 2;
   localparam int L     = 400;
   localparam int EB    = AW + 2;
   localparam int BB    = AW + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_period;
   logic [RPT_W-1:0] wr_repeat;
   logic             start;
   logic             stop;
   logic             loop;
   logic             o_clk;
   logic             o_edge;
   logic             o_busy;
   logic             o_done;
   logic [AW-1:0]    o_idx;

   int checks   = 0;
   int failures = 0;

   int tp [DEPTH];
   int tr [DEPTH];
   logic [AW+3:0] exp_v [L];

   cntclk_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RPT_W(RPT_W)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_wr_en     (wr_en),
      .i_wr_addr   (wr_addr),
      .i_wr_period (wr_period),
      .i_wr_repeat (wr_repeat),
      .i_start     (start),
      .i_stop      (stop),
      .i_loop      (loop),
      .o_clk       (o_clk),
      .o_edge      (o_edge),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_idx       (o_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp, input int t);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp);
      end
   endtask

   function automatic logic [AW+3:0] pk(input int c, input int e, input int b, input int d, input int k);
      return {c[0], e[0], b[0], d[0], k[AW-1:0]};
   endfunction

   task automatic wr(input int a, input int p, input int r);
      wr_en     = 1'b1;
      wr_addr   = a[AW-1:0];
      wr_period = p[WIDTH-1:0];
      wr_repeat = r[RPT_W-1:0];
      @(posedge clk); #1;
      wr_en = 1'b0;
      tp[a] = p;
      tr[a] = r;
   endtask

   // Expected outputs after each edge, built from the entry schedule:
   // entry k occupies 2*R*Pe cycles, toggling every Pe cycles from its start edge.
   task automatic build_model(input int lp, input int stop_at, output int run_len);
      int s, k, pe, n, nxt, fin;
      for (int i = 0; i < L; i++) exp_v[i] = '0;
      run_len = L - 1;
      if (tr[0] == 0) begin
         exp_v[0] = pk(0, 0, 0, 1, 0);
         run_len  = 4;
         return;
      end
      s = 0; k = 0; fin = -1;
      while (s < L && fin < 0) begin
         pe = (tp[k] == 0) ? 1 : tp[k];
         n  = 2 * tr[k] * pe;
         for (int t = s; t < s + n && t < L; t++)
            exp_v[t] = pk(((t - s) / pe) % 2, (t > s && (t - s) % pe == 0) ? 1 : 0, 1, 0, k);
         if (s > 0) exp_v[s][EB] = 1'b1;
         nxt = k + 1;
         if (k == DEPTH - 1) begin
            if (lp != 0) nxt = 0; else fin = s + n;
         end else if (tr[nxt] == 0) begin
            if (lp != 0) nxt = 0; else fin = s + n;
         end
         k = nxt;
         s = s + n;
      end
      if (fin >= 0 && fin < L) begin
         exp_v[fin] = pk(0, 1, 0, 1, 0);
         run_len = fin + 4;
      end
      if (stop_at > 0 && stop_at < L && exp_v[stop_at-1][BB]) begin
         for (int t = stop_at; t < L; t++) exp_v[t] = '0;
         if (stop_at + 4 < run_len) run_len = stop_at + 4;
      end
   endtask

   task automatic run_model_test(input string tag, input int lp, input int stop_at, input int extra);
      int rl;
      build_model(lp, stop_at, rl);
      start = 1'b1;
      loop  = lp[0];
      stop  = 1'b0;
      for (int t = 0; t < rl; t++) begin
         @(posedge clk); #1;
         check(tag, {26'd0, o_clk, o_edge, o_busy, o_done, o_idx}, {26'd0, exp_v[t]}, t);
         start = (extra != 0) && exp_v[t][BB] && ($urandom_range(0, 3) == 0);
         stop  = (t + 1 == stop_at);
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   initial begin
      int  tog;
      bit  e;
      int  lp, sa;

      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_period = '0; wr_repeat = '0;
      start = 1'b0; stop = 1'b0; loop = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin tp[i] = 0; tr[i] = 0; end
      #12;
      check("reset_outputs", {27'd0, o_clk, o_edge, o_busy, o_done, o_idx}, 32'd0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // two-entry burst: 3/2 then 1/1, entry 2 terminates the list
      wr(0, 3, 2); wr(1, 1, 1); wr(2, 0, 0); wr(3, 0, 0);
      run_model_test("plan_burst", 0, 0, 1);

      // every entry toggles each cycle, looping until aborted
      for (int i = 0; i < DEPTH; i++) wr(i, 0, 1);
      run_model_test("loop_stop", 1, 19, 0);

      // abort on the very edge a toggle is due
      wr(0, 2, 1); wr(1, 0, 0);
      run_model_test("stop_on_toggle", 0, 2, 0);

      // rewrite entry0 mid half-period, then again on a reload edge (old value must be used)
      wr(0, 4, 3); wr(1, 0, 0); wr(2, 0, 0); wr(3, 0, 0);
      start = 1'b1; loop = 1'b0; tog = 0;
      for (int t = 0; t < 24; t++) begin
         @(posedge clk); #1;
         e = (t == 4 || t == 6 || t == 8 || t == 10 || t == 15 || t == 20);
         if (e) tog++;
         check("midrun_write", {28'd0, o_clk, o_edge, o_busy, o_done},
               {28'd0, tog[0], e, (t < 20), (t == 20)}, t);
         start     = (t == 2 || t == 9);
         wr_en     = (t == 1 || t == 7);
         wr_addr   = '0;
         wr_period = (t == 1) ? WIDTH'(2) : WIDTH'(5);
         wr_repeat = RPT_W'(3);
      end
      start = 1'b0; wr_en = 1'b0;
      tp[0] = 5;

      // asynchronous reset in the middle of a run clears outputs and the table
      wr(0, 3, 2); wr(1, 1, 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      check("pre_reset_run", {30'd0, o_clk, o_busy}, 32'd3, 4);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset", {27'd0, o_clk, o_edge, o_busy, o_done, o_idx}, 32'd0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin tp[i] = 0; tr[i] = 0; end
      run_model_test("post_reset_empty", 0, 0, 0);

      // randomized tables, loop mode and abort points
      for (int it = 0; it < 25; it++) begin
         for (int i = 0; i < DEPTH; i++)
            wr(i, $urandom_range(0, 4), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3));
         lp = $urandom_range(0, 1);
         sa = (lp != 0 || $urandom_range(0, 2) == 0) ? $urandom_range(1, 120) : 0;
         run_model_test("random_run", lp, sa, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
